// File: rtl/aidan_mccoy.sv
// 8-bit accumulator processor for an 8-in/8-out tile slot.
// One 6-bit instruction per clock arrives on io_in[5:0]; results leave only via OUT/OUTPC.
module aidan_mccoy (
   input  logic [7:0] io_in,
   output logic [7:0] io_out
);

   localparam logic [2:0] OP_LDI  = 3'b000;
   localparam logic [2:0] OP_LD   = 3'b001;
   localparam logic [2:0] OP_ST   = 3'b010;
   localparam logic [2:0] OP_ADD  = 3'b011;
   localparam logic [2:0] OP_SUB  = 3'b100;
   localparam logic [2:0] OP_NAND = 3'b101;
   localparam logic [2:0] OP_MISC = 3'b110;
   localparam logic [2:0] OP_BRZ  = 3'b111;

   localparam logic [2:0] MX_SHL   = 3'b000;
   localparam logic [2:0] MX_SHR   = 3'b001;
   localparam logic [2:0] MX_INC   = 3'b010;
   localparam logic [2:0] MX_DEC   = 3'b011;
   localparam logic [2:0] MX_NOT   = 3'b100;
   localparam logic [2:0] MX_LDC   = 3'b101;
   localparam logic [2:0] MX_OUT   = 3'b110;
   localparam logic [2:0] MX_OUTPC = 3'b111;

   logic       clk_sys;
   logic       rst;
   logic [2:0] op;
   logic [2:0] k;

   assign clk_sys = io_in[7];
   assign rst     = io_in[6];
   assign op      = io_in[5:3];
   assign k       = io_in[2:0];

   logic [7:0] acc_q, acc_d;
   logic [7:0] pc_q,  pc_d;
   logic       c_q,   c_d;
   logic [7:0] out_q, out_d;
   logic [7:0] r_q [0:7];
   logic [7:0] r_d [0:7];

   logic [7:0] rk;
   logic [8:0] sum9;
   logic [8:0] diff9;
   logic [8:0] inc9;
   logic [8:0] dec9;
   logic [7:0] pc_inc;

   assign rk     = r_q[k];
   assign sum9   = {1'b0, acc_q} + {1'b0, rk};
   // Bit 8 of the 9-bit difference is the unsigned borrow.
   assign diff9  = {1'b0, acc_q} - {1'b0, rk};
   assign inc9   = {1'b0, acc_q} + 9'd1;
   assign dec9   = {1'b0, acc_q} - 9'd1;
   assign pc_inc = pc_q + 8'd1;

   always_comb begin
      acc_d = acc_q;
      pc_d  = pc_inc;
      c_d   = c_q;
      out_d = out_q;
      r_d   = r_q;
      case (op)
         OP_LDI:  acc_d = {5'b0, k};
         OP_LD:   acc_d = rk;
         OP_ST:   r_d[k] = acc_q;
         OP_ADD:  {c_d, acc_d} = sum9;
         OP_SUB:  {c_d, acc_d} = diff9;
         OP_NAND: acc_d = ~(acc_q & rk);
         OP_MISC: begin
            case (k)
               MX_SHL:   begin c_d = acc_q[7]; acc_d = {acc_q[6:0], 1'b0}; end
               MX_SHR:   begin c_d = acc_q[0]; acc_d = {1'b0, acc_q[7:1]}; end
               MX_INC:   {c_d, acc_d} = inc9;
               MX_DEC:   {c_d, acc_d} = dec9;
               MX_NOT:   acc_d = ~acc_q;
               MX_LDC:   acc_d = {7'b0, c_q};
               MX_OUT:   out_d = acc_q;
               MX_OUTPC: out_d = pc_q;
               default:  acc_d = acc_q;
            endcase
         end
         OP_BRZ: begin
            if (acc_q == 8'd0) pc_d = pc_q + {5'b0, k};
         end
         default: acc_d = acc_q;
      endcase
   end

   always_ff @(posedge clk_sys) begin
      if (rst) begin
         acc_q <= 8'd0;
         pc_q  <= 8'd0;
         c_q   <= 1'b0;
         out_q <= 8'd0;
         for (int i = 0; i < 8; i++) r_q[i] <= 8'd0;
      end else begin
         acc_q <= acc_d;
         pc_q  <= pc_d;
         c_q   <= c_d;
         out_q <= out_d;
         r_q   <= r_d;
      end
   end

   assign io_out = out_q;

endmodule

// File: tb/tb_aidan_mccoy.sv
// Bench for aidan_mccoy: directed programs with literal results plus random
// instruction streams checked each cycle against an arithmetic model.
module tb_aidan_mccoy;

   logic       clk_sys;
   logic       rst_in;
   logic [5:0] instr;
   logic [7:0] io_out;

   int tests;
   int fails;

   int m_acc, m_pc, m_c, m_out;
   int m_r [8];
   bit m_valid;

   aidan_mccoy dut (
      .io_in  ({clk_sys, rst_in, instr}),
      .io_out (io_out)
   );

   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   // Reference model: state as plain integers, rules as arithmetic mod 256.
   always @(posedge clk_sys) begin
      int op, k, rv;
      op = int'(instr[5:3]);
      k  = int'(instr[2:0]);
      if (rst_in) begin
         m_acc = 0; m_pc = 0; m_c = 0; m_out = 0;
         for (int i = 0; i < 8; i++) m_r[i] = 0;
         m_valid = 1'b1;
      end else if (m_valid) begin
         rv = m_r[k];
         if (op == 7 && m_acc == 0) m_pc = (m_pc + k) % 256;
         else begin
            if (op == 6 && k == 7) m_out = m_pc;
            m_pc = (m_pc + 1) % 256;
         end
         case (op)
            0: m_acc = k;
            1: m_acc = rv;
            2: m_r[k] = m_acc;
            3: begin m_c = (m_acc + rv > 255) ? 1 : 0; m_acc = (m_acc + rv) % 256; end
            4: begin m_c = (m_acc < rv) ? 1 : 0; m_acc = (m_acc - rv + 256) % 256; end
            5: m_acc = 255 - (m_acc & rv);
            6: case (k)
                  0: begin m_c = m_acc / 128; m_acc = (m_acc * 2) % 256; end
                  1: begin m_c = m_acc % 2; m_acc = m_acc / 2; end
                  2: begin m_c = (m_acc == 255) ? 1 : 0; m_acc = (m_acc + 1) % 256; end
                  3: begin m_c = (m_acc == 0) ? 1 : 0; m_acc = (m_acc + 255) % 256; end
                  4: m_acc = 255 - m_acc;
                  5: m_acc = m_c;
                  6: m_out = m_acc;
                  default: ;
               endcase
            default: ;
         endcase
      end
   end

   always @(negedge clk_sys) begin
      if (m_valid) begin
         tests++;
         if (int'(io_out) != m_out) begin
            fails++;
            $display("FAIL model_cmp t=%0t io_out=%02h expected=%02h", $time, io_out, m_out[7:0]);
         end
      end
   end

   task automatic run(input logic r, input logic [2:0] op, input logic [2:0] k);
      @(negedge clk_sys);
      rst_in = r;
      instr  = {op, k};
      @(posedge clk_sys);
      #1;
   endtask

   task automatic check_lit(input string name, input logic [7:0] exp);
      tests++;
      if (io_out !== exp) begin
         fails++;
         $display("FAIL %s io_out=%02h expected=%02h", name, io_out, exp);
      end
   endtask

   task automatic do_reset();
      run(1'b1, 3'($urandom), 3'($urandom));
   endtask

   initial begin
      tests = 0; fails = 0; m_valid = 1'b0;
      rst_in = 1'b1; instr = 6'd0;

      // Reset and PC export
      do_reset(); do_reset();
      check_lit("reset_out", 8'h00);
      run(0, 3'd6, 3'd7); check_lit("outpc_first", 8'h00);
      run(0, 3'd6, 3'd7); check_lit("outpc_second", 8'h01);

      // Load/store/add/out, then carry stays 0
      run(0, 3'd0, 3'd5); run(0, 3'd2, 3'd2); run(0, 3'd0, 3'd3);
      run(0, 3'd3, 3'd2); run(0, 3'd6, 3'd6); check_lit("add_out", 8'h08);
      run(0, 3'd6, 3'd5); run(0, 3'd6, 3'd6); check_lit("add_carry0", 8'h00);

      // DEC wrap and ADD carry
      run(0, 3'd0, 3'd0); run(0, 3'd6, 3'd3); run(0, 3'd2, 3'd1);
      run(0, 3'd3, 3'd1); run(0, 3'd6, 3'd6); check_lit("wrap_add", 8'hFE);
      run(0, 3'd6, 3'd5); run(0, 3'd6, 3'd6); check_lit("wrap_carry", 8'h01);

      // Subtract with borrow
      run(0, 3'd0, 3'd2); run(0, 3'd2, 3'd0); run(0, 3'd0, 3'd1);
      run(0, 3'd4, 3'd0); run(0, 3'd6, 3'd6); check_lit("sub_out", 8'hFF);
      run(0, 3'd6, 3'd5); run(0, 3'd6, 3'd6); check_lit("sub_borrow", 8'h01);

      // Branch taken / not taken
      do_reset();
      run(0, 3'd0, 3'd0); run(0, 3'd7, 3'd4); run(0, 3'd6, 3'd7);
      check_lit("brz_taken", 8'h05);
      do_reset();
      run(0, 3'd0, 3'd1); run(0, 3'd7, 3'd4); run(0, 3'd6, 3'd7);
      check_lit("brz_not_taken", 8'h02);
      // BRZ 0 with Z holds PC
      do_reset();
      run(0, 3'd7, 3'd0); run(0, 3'd7, 3'd0); run(0, 3'd6, 3'd7);
      check_lit("brz_hold", 8'h00);

      // NAND, SHR, mid-program reset
      run(0, 3'd0, 3'd6); run(0, 3'd2, 3'd3); run(0, 3'd0, 3'd7);
      run(0, 3'd5, 3'd3); run(0, 3'd6, 3'd6); check_lit("nand_out", 8'hF9);
      run(0, 3'd6, 3'd1); run(0, 3'd6, 3'd6); check_lit("shr_out", 8'h7C);
      do_reset(); check_lit("mid_reset", 8'h00);
      run(0, 3'd6, 3'd7); check_lit("mid_reset_pc", 8'h00);

      // Random streams, OUT/OUTPC biased so state becomes visible often
      for (int n = 0; n < 3000; n++) begin
         logic [2:0] op, k;
         int sel;
         sel = int'($urandom_range(0, 99));
         op  = 3'($urandom);
         k   = 3'($urandom);
         if (sel < 20) begin op = 3'd6; k = 3'd6; end
         else if (sel < 24) begin op = 3'd6; k = 3'd7; end
         run((sel == 99) ? 1'b1 : 1'b0, op, k);
      end

      @(negedge clk_sys);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/aidan_mccoy.md
Name: aidan_mccoy

Overview:
- Tiny 8-bit accumulator processor for an 8-in/8-out tile slot.
- Clock and reset are carried on the top two input pins. Each clock cycle the block executes one 6-bit instruction taken directly from the remaining six input pins; there is no instruction memory.
- Results become visible on the 8-bit output only through an explicit OUT instruction.
- A program counter is maintained for the external sequencer and can be exported with OUTPC.

Parameters:
- None (all widths fixed).

Ports:
- io_in[7]  input  1  clk; all state updates on its rising edge.
- io_in[6]  input  1  reset; synchronous, active-high.
- io_in[5:0]  input  6  instr; instruction sampled on each rising clk edge when reset is low.
- io_out  output  8  Output register OUT, driven directly from a flop.

Behaviour:
- State:
  - ACC: 8-bit accumulator.
  - R0..R7: eight 8-bit registers.
  - PC: 8-bit program counter.
  - C: 1-bit carry flag.
  - OUT: 8-bit output register.
  - Z = (ACC == 0), combinational, not stored.
- Reset: on a rising edge with reset=1, all of the above are cleared to 0, so io_out=0 from the next cycle on. Reset overrides any instruction present, including mid-program.
- Instruction encoding: op = instr[5:3], k = instr[2:0] (register index or immediate). Every instruction completes in one cycle and its result is visible the cycle after the edge.
- PC:
  - Becomes PC+1 (mod 256) every non-reset edge.
  - Exception: a taken BRZ.
- Instruction set:
  - 000 LDI k: ACC <= {5'b0,k}.
  - 001 LD k: ACC <= R[k].
  - 010 ST k: R[k] <= ACC.
  - 011 ADD k: {C,ACC} <= ACC + R[k]. 9-bit sum; ACC wraps mod 256; C = carry out.
  - 100 SUB k: ACC <= ACC - R[k] mod 256; C <= 1 if ACC < R[k] (unsigned borrow), else 0.
  - 101 NAND k: ACC <= ~(ACC & R[k]); C unchanged.
  - 110 misc, selected by k:
    - 000 SHL: C <= ACC[7]; ACC <= ACC<<1.
    - 001 SHR: C <= ACC[0]; ACC <= ACC>>1 (logical).
    - 010 INC: ACC+1, wraps 255->0, C <= 1 on wrap, else 0.
    - 011 DEC: ACC-1, wraps 0->255, C <= 1 on wrap, else 0.
    - 100 NOT: ACC <= ~ACC.
    - 101 LDC: ACC <= {7'b0,C}.
    - 110 OUT: OUT <= ACC.
    - 111 OUTPC: OUT <= PC, the PC of this instruction before increment.
  - 111 BRZ k: if Z, PC <= PC + {5'b0,k} (mod 256), else PC <= PC+1.
    - BRZ 0 with Z=1 holds PC.
    - ACC, registers and C unchanged.
- Flag rules:
  - C changes only on ADD, SUB, SHL, SHR, INC and DEC.
  - All other instructions leave C unchanged, including LD/LDI.
- Register access: ST then LD/ADD of the same register on the next cycle sees the new value. No hazards exist, since there is a single write per cycle.
- OUT is the only source of io_out and holds its value until the next OUT/OUTPC or reset.

Test Plan:
- Reset: hold reset=1 two cycles with random instr -> io_out=0. Then OUTPC on the first cycle after reset -> io_out=0x00. OUTPC on the following cycle -> io_out=0x01.
- Load/store/out: LDI 5, ST R2, LDI 3, ADD R2, OUT -> io_out=0x08 one cycle after the OUT edge; C=0.
- Wrap and carry: LDI 0, DEC (ACC=0xFF, C=1), ST R1, ADD R1 (ACC=0xFE, C=1), OUT -> io_out=0xFE. Then LDC, OUT -> io_out=0x01.
- Subtract borrow: LDI 2, ST R0, LDI 1, SUB R0, OUT -> io_out=0xFF; LDC, OUT -> 0x01.
- Branch: after reset, LDI 0 (PC0), BRZ 4 (PC1, taken), OUTPC -> io_out=0x05. Repeat with LDI 1 before BRZ 4 -> OUTPC shows 0x02 (not taken).
- Logic/shift plus reset mid-program: LDI 6, ST R3, LDI 7, NAND R3, OUT -> 0xF9. SHR, OUT -> 0x7C. Then assert reset for one cycle -> io_out=0x00 and PC=0.
